// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
//   Shared definitions for the 2-read / 1-write register bank:
//   default parameter values and the clear-sequencer state encoding.
//   No ports.
package reg_bank_pkg;

    localparam int DEF_DATA_BIT = 48;
    localparam int DEF_REG_NUM  = 4;
    localparam int DEF_ADDR_NUM = 2;

    // ST_CLEAR walks the entries one per cycle, zeroing data and flag.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_rport.sv
// reg_bank_rport
//   One registered read port of the register bank (latency 1).
//   Optional macro REG_BANK_BYPASS_EN: when defined, a read that hits the
//   address being written in the same cycle returns the incoming write data
//   with rvld=1; otherwise it returns the pre-write entry content and flag.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   re, raddr         read request and address
//   mem_data/mem_flag current bank content and written flags
//   wr_acc/waddr/wdata accepted write this cycle (bypass source)
//   rdata, rvld       registered read data, response strobe (entry written)
module reg_bank_rport import reg_bank_pkg::*; #(
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int ADDR_NUM = DEF_ADDR_NUM
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              re,
    input  logic [ADDR_NUM-1:0]               raddr,
    input  logic [REG_NUM-1:0][DATA_BIT-1:0]  mem_data,
    input  logic [REG_NUM-1:0]                mem_flag,
    input  logic                              wr_acc,
    input  logic [ADDR_NUM-1:0]               waddr,
    input  logic [DATA_BIT-1:0]               wdata,
    output logic [DATA_BIT-1:0]               rdata,
    output logic                              rvld
);

    logic                in_range;
    logic [DATA_BIT-1:0] sel_data;
    logic                sel_vld;

    assign in_range = (32'(raddr) < REG_NUM);

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        // Out-of-range addresses read as an unwritten zero entry.
        if (in_range) begin
            sel_data = mem_data[raddr];
            sel_vld  = mem_flag[raddr];
        end
`ifdef REG_BANK_BYPASS_EN
        // wr_acc already implies waddr is in range.
        if (wr_acc && (waddr == raddr)) begin
            sel_data = wdata;
            sel_vld  = 1'b1;
        end
`endif
    end

`ifndef REG_BANK_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_acc, waddr, wdata};
`endif

    // Data holds when idle; rvld is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rvld  <= 1'b0;
        end else if (re) begin
            rdata <= sel_data;
            rvld  <= sel_vld;
        end else begin
            rvld  <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_2r1w.sv
// reg_bank_2r1w
//   REG_NUM x DATA_BIT register bank with one write port, two registered
//   read ports and a sequential bulk clear (one entry per cycle).
//   Optional macro REG_BANK_BYPASS_EN enables same-cycle write-through to
//   the read ports (see reg_bank_rport).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_we, i_waddr, i_wdata     write request
//   i_re0/1, i_raddr0/1        read requests
//   o_rdata0/1, o_rvld0/1      registered read data / valid (entry written)
//   i_clr                      bulk-clear start pulse
//   o_busy                     clear sequence in progress
module reg_bank_2r1w import reg_bank_pkg::*; #(
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int ADDR_NUM = DEF_ADDR_NUM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [ADDR_NUM-1:0] i_waddr,
    input  logic [DATA_BIT-1:0] i_wdata,
    input  logic                i_re0,
    input  logic [ADDR_NUM-1:0] i_raddr0,
    input  logic                i_re1,
    input  logic [ADDR_NUM-1:0] i_raddr1,
    output logic [DATA_BIT-1:0] o_rdata0,
    output logic                o_rvld0,
    output logic [DATA_BIT-1:0] o_rdata1,
    output logic                o_rvld1,
    input  logic                i_clr,
    output logic                o_busy
);

    localparam logic [ADDR_NUM-1:0] LAST = ADDR_NUM'(REG_NUM - 1);

    logic [REG_NUM-1:0][DATA_BIT-1:0] mem_data;
    logic [REG_NUM-1:0]               mem_flag;

    state_t              state, state_nxt;
    logic [ADDR_NUM-1:0] cnt, cnt_nxt;
    logic                clr_en;
    logic                wr_acc;

    // Writes only land in IDLE; a coinciding clear start takes priority.
    assign wr_acc = (state == ST_IDLE) && i_we && !i_clr &&
                    (32'(i_waddr) < REG_NUM);
    assign o_busy = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // i_clr is not looked at in ST_CLEAR, so a clear cannot restart.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_clr) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data <= '0;
            mem_flag <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (clr_en && (cnt == ADDR_NUM'(i))) begin
                    mem_data[i] <= '0;
                    mem_flag[i] <= 1'b0;
                end else if (wr_acc && (i_waddr == ADDR_NUM'(i))) begin
                    mem_data[i] <= i_wdata;
                    mem_flag[i] <= 1'b1;
                end
            end
        end
    end

    // Two identical read ports, gathered into packed vectors for the loop.
    logic [1:0]                re_v, rvld_v;
    logic [1:0][ADDR_NUM-1:0]  raddr_v;
    logic [1:0][DATA_BIT-1:0]  rdata_v;

    assign re_v    = {i_re1, i_re0};
    assign raddr_v = {i_raddr1, i_raddr0};

    for (genvar p = 0; p < 2; p++) begin : g_rport
        reg_bank_rport #(
            .DATA_BIT (DATA_BIT),
            .REG_NUM  (REG_NUM),
            .ADDR_NUM (ADDR_NUM)
        ) u_rport (
            .clk      (clk),
            .rst_n    (rst_n),
            .re       (re_v[p]),
            .raddr    (raddr_v[p]),
            .mem_data (mem_data),
            .mem_flag (mem_flag),
            .wr_acc   (wr_acc),
            .waddr    (i_waddr),
            .wdata    (i_wdata),
            .rdata    (rdata_v[p]),
            .rvld     (rvld_v[p])
        );
    end

    assign o_rdata0 = rdata_v[0];
    assign o_rvld0  = rvld_v[0];
    assign o_rdata1 = rdata_v[1];
    assign o_rvld1  = rvld_v[1];

endmodule
